// File: rtl/i2c_sniff_fifo.sv
// i2c_sniff_fifo: passive I2C listener that filters the bus, decodes START/STOP/frames
// and queues tagged {kind, byte, nack} entries in a show-ahead FIFO.
module i2c_sniff_fifo #(
    parameter int         SYNC_STAGES   = 2,
    parameter int         FILT_LEN      = 3,
    parameter int         DEPTH         = 16,
    parameter int         ADDR_MATCH_EN = 0,
    parameter logic [6:0] MATCH_ADDR    = 7'h00
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     scl_in,
    input  logic                     sda_in,
    input  logic                     out_ready,
    input  logic                     ovf_clr,
    output logic                     out_valid,
    output logic [10:0]              out_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     ovf,
    output logic                     bus_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0]    FILT_TOP = 4'(FILT_LEN - 1);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, SKIP} state_t;

    logic [1:0] raw, filt, filt_d;
    assign raw = {sda_in, scl_in};

    // index 0 is SCL, index 1 is SDA; both lines share identical delay so ordering is preserved
    for (genvar i = 0; i < 2; i++) begin : g_line
        logic [SYNC_STAGES-1:0] sync_q;
        logic [3:0]             run;
        logic                   f_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                sync_q <= '1;
                run    <= '0;
                f_q    <= 1'b1;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], raw[i]};
                if (sync_q[SYNC_STAGES-1] == f_q)
                    run <= '0;
                else if (run == FILT_TOP) begin
                    f_q <= sync_q[SYNC_STAGES-1];
                    run <= '0;
                end else
                    run <= run + 4'd1;
            end
        end
        assign filt[i] = f_q;
    end

    logic scl_rise, start_ev, stop_ev;
    assign scl_rise = filt[0] & ~filt_d[0];
    assign start_ev = filt[0] & filt_d[0] & filt_d[1] & ~filt[1];
    assign stop_ev  = filt[0] & filt_d[0] & ~filt_d[1] & filt[1];

    state_t      state, state_n;
    logic [3:0]  bit_cnt, cnt_n;
    logic [7:0]  shift, shift_n;
    logic        busy_n, push, push_n, in_frame, addr_miss;
    logic [10:0] push_data, pdata_n;

    assign in_frame  = (state == ADDR) || (state == DATA);
    assign addr_miss = (ADDR_MATCH_EN != 0) && (shift[7:1] != MATCH_ADDR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            bus_busy  <= 1'b0;
            push      <= 1'b0;
            push_data <= '0;
            filt_d    <= 2'b11;
        end else begin
            state     <= state_n;
            bit_cnt   <= cnt_n;
            shift     <= shift_n;
            bus_busy  <= busy_n;
            push      <= push_n;
            push_data <= pdata_n;
            filt_d    <= filt;
        end
    end

    // partial bits of a truncated frame stay right-aligned in shift
    always_comb begin
        state_n = state;
        cnt_n   = bit_cnt;
        shift_n = shift;
        busy_n  = bus_busy;
        push_n  = 1'b0;
        pdata_n = '0;
        if (start_ev) begin
            state_n = ADDR;
            cnt_n   = '0;
            shift_n = '0;
            busy_n  = 1'b1;
            push_n  = in_frame && (bit_cnt != 4'd0);
            pdata_n = {2'b11, shift, 1'b1};
        end else if (stop_ev) begin
            state_n = IDLE;
            cnt_n   = '0;
            shift_n = '0;
            busy_n  = 1'b0;
            push_n  = in_frame;
            pdata_n = {2'b10, 9'd0};
        end else if (scl_rise && state != IDLE) begin
            if (bit_cnt == 4'd8) begin
                cnt_n   = '0;
                shift_n = '0;
                push_n  = (state == DATA) || (state == ADDR && !addr_miss);
                pdata_n = {(state == ADDR) ? 2'b01 : 2'b00, shift, filt[1]};
                state_n = (state == ADDR) ? (addr_miss ? SKIP : DATA) : state;
            end else begin
                cnt_n   = bit_cnt + 4'd1;
                shift_n = {shift[6:0], filt[1]};
            end
        end
    end

    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, pop, wr;

    assign full      = fifo_level == FULL_LVL;
    assign out_valid = fifo_level != '0;
    assign pop       = out_valid & out_ready;
    assign wr        = push & (~full | pop);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            ovf        <= 1'b0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (wr && !pop)
                fifo_level <= fifo_level + LVL_ONE;
            else if (pop && !wr)
                fifo_level <= fifo_level - LVL_ONE;
            ovf <= (push & ~wr) | (ovf & ~ovf_clr);
        end
    end
endmodule

// File: tb/tb_i2c_sniff_fifo.sv
// tb_i2c_sniff_fifo: drives I2C line activity, predicts entries with a bus-event model
// and scores every popped entry plus status outputs.
module tb_i2c_sniff_fifo;
    localparam int DEPTH = 4;
    localparam int H     = 8;

    logic        clk = 1'b0, rst = 1'b1, scl_in = 1'b1, sda_in = 1'b1, out_ready = 1'b0, ovf_clr = 1'b0;
    logic        out_valid, ovf, bus_busy;
    logic [10:0] out_data;
    logic [2:0]  fifo_level;

    i2c_sniff_fifo #(
        .SYNC_STAGES(2), .FILT_LEN(3), .DEPTH(DEPTH), .ADDR_MATCH_EN(1), .MATCH_ADDR(7'h50)
    ) dut (
        .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .out_ready(out_ready),
        .ovf_clr(ovf_clr), .out_valid(out_valid), .out_data(out_data), .fifo_level(fifo_level),
        .ovf(ovf), .bus_busy(bus_busy)
    );

    always #5 clk = ~clk;

    int          total = 0, passed = 0, busy_cnt = 0;
    logic [10:0] exp_q[$], got_q[$];
    logic [10:0] sb_e;
    int          m_st = 0, m_cnt = 0, m_val = 0;
    bit          m_busy = 0, m_ovf = 0, rdy_rand = 0, rdy_val = 0;

    function automatic logic [10:0] ent(input logic [1:0] k, input logic [7:0] b, input logic n);
        return {k, b, n};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h want %0h", name, got, want);
    endtask

    // model: state 0 idle, 1 address frame, 2 data frames, 3 skipping a foreign transaction
    function automatic void m_push(input logic [10:0] e);
        if (exp_q.size() >= DEPTH) m_ovf = 1;
        else exp_q.push_back(e);
    endfunction

    function automatic void m_start();
        if ((m_st == 1 || m_st == 2) && m_cnt != 0) m_push(ent(2'b11, m_val[7:0], 1'b1));
        m_st = 1; m_cnt = 0; m_val = 0; m_busy = 1;
    endfunction

    function automatic void m_stop();
        if (m_st == 1 || m_st == 2) m_push(ent(2'b10, 8'h00, 1'b0));
        m_st = 0; m_cnt = 0; m_val = 0; m_busy = 0;
    endfunction

    function automatic void m_bit(input logic b);
        if (m_st == 0) return;
        if (m_cnt < 8) begin
            m_val = m_val * 2 + int'(b);
            m_cnt++;
        end else begin
            if (m_st == 1) begin
                if ((m_val >> 1) == 'h50) begin
                    m_push(ent(2'b01, m_val[7:0], b));
                    m_st = 2;
                end else m_st = 3;
            end else if (m_st == 2) m_push(ent(2'b00, m_val[7:0], b));
            m_cnt = 0; m_val = 0;
        end
    endfunction

    always @(negedge clk) begin
        if (bus_busy) busy_cnt++;
        if (!rst && out_valid && out_ready) begin
            got_q.push_back(out_data);
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL entry: got unexpected %h, model queue empty", out_data);
            end else begin
                sb_e = exp_q.pop_front();
                chk("entry", 32'(out_data), 32'(sb_e));
            end
        end
    end

    initial forever begin
        @(posedge clk); #1;
        out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_scl(input logic v);
        if (v && !scl_in) m_bit(sda_in);
        scl_in = v;
        wait_cyc(H);
    endtask

    task automatic set_sda(input logic v);
        if (scl_in && sda_in && !v) m_start();
        if (scl_in && !sda_in && v) m_stop();
        sda_in = v;
        wait_cyc(H);
    endtask

    task automatic send_bit(input logic b);
        set_sda(b); set_scl(1'b1); set_scl(1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic n);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        send_bit(n);
    endtask

    task automatic bus_start();
        if (!scl_in) begin set_sda(1'b1); set_scl(1'b1); end
        set_sda(1'b0); set_scl(1'b0);
        chk("busy_after_start", bus_busy, m_busy);
    endtask

    task automatic bus_stop();
        set_sda(1'b0); set_scl(1'b1); set_sda(1'b1);
        chk("busy_after_stop", bus_busy, m_busy);
    endtask

    task automatic drain();
        rdy_rand = 0; rdy_val = 1;
        for (int i = 0; i < 400 && (exp_q.size() != 0 || out_valid); i++) wait_cyc(1);
        chk("drain_model_empty", exp_q.size(), 0);
        chk("drain_level", fifo_level, 0);
    endtask

    task automatic pin(input string nm, input logic [10:0] w0, w1, w2, w3);
        chk({nm, "_count"}, got_q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk(nm, (i < got_q.size()) ? 32'(got_q[i]) : 32'hffff_ffff,
                32'((i == 0) ? w0 : (i == 1) ? w1 : (i == 2) ? w2 : w3));
    endtask

    task automatic apply_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        m_st = 0; m_cnt = 0; m_val = 0; m_busy = 0; m_ovf = 0;
    endtask

    int c0;
    logic [7:0] a;

    initial begin
        wait_cyc(3);
        rst = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", bus_busy, 0);
        chk("rst_data", out_data, 0);
        wait_cyc(10);

        rdy_val = 1; got_q.delete();
        bus_start();
        chk("t1_busy_high", bus_busy, 1);
        send_byte(8'hA0, 1'b0); send_byte(8'h3C, 1'b0); send_byte(8'hFF, 1'b1);
        chk("t1_busy_mid", bus_busy, 1);
        bus_stop();
        chk("t1_busy_low", bus_busy, 0);
        drain();
        pin("t1", ent(2'b01, 8'hA0, 1'b0), ent(2'b00, 8'h3C, 1'b0), ent(2'b00, 8'hFF, 1'b1), ent(2'b10, 8'h00, 1'b0));

        got_q.delete(); c0 = busy_cnt;
        sda_in = 1'b0; wait_cyc(2); sda_in = 1'b1; wait_cyc(20);
        chk("glitch2_busy", busy_cnt - c0, 0);
        chk("glitch2_valid", out_valid, 0);
        m_start(); sda_in = 1'b0; wait_cyc(4);
        m_stop();  sda_in = 1'b1; wait_cyc(20);
        chk("glitch4_busy_seen", busy_cnt > c0, 1);
        drain();
        chk("glitch4_count", got_q.size(), 1);
        chk("glitch4_entry", got_q.size() > 0 ? 32'(got_q[0]) : 32'hffff_ffff, 32'(ent(2'b10, 8'h00, 1'b0)));

        got_q.delete();
        bus_start(); send_byte(8'hA0, 1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        bus_start(); send_byte(8'hA1, 1'b0); bus_stop();
        drain();
        pin("trunc", ent(2'b01, 8'hA0, 1'b0), ent(2'b11, 8'h17, 1'b1), ent(2'b01, 8'hA1, 1'b0), ent(2'b10, 8'h00, 1'b0));

        rdy_val = 0; wait_cyc(2);
        bus_start(); send_byte(8'hA0, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i), 1'b0);
        wait_cyc(10);
        chk("ovf_level", fifo_level, 4);
        chk("ovf_level_model", fifo_level, exp_q.size());
        chk("ovf_flag", ovf, 1);
        chk("ovf_flag_model", ovf, m_ovf);
        chk("ovf_head", out_data, ent(2'b01, 8'hA0, 1'b0));
        bus_stop();
        chk("ovf_still_set", ovf, 1);
        ovf_clr = 1'b1; wait_cyc(1); ovf_clr = 1'b0; wait_cyc(1);
        m_ovf = 0;
        chk("ovf_cleared", ovf, 0);
        chk("ovf_level_kept", fifo_level, 4);
        drain();

        got_q.delete();
        bus_start(); send_byte(8'hA2, 1'b0); send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b1); bus_stop();
        wait_cyc(10);
        chk("filt_none", got_q.size(), 0);
        chk("filt_level", fifo_level, 0);
        bus_start(); send_byte(8'hA0, 1'b0); send_byte(8'h5A, 1'b0); bus_stop();
        drain();
        chk("filt_match_count", got_q.size(), 3);

        rdy_val = 0; wait_cyc(2);
        bus_start(); send_byte(8'hA0, 1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        wait_cyc(4);
        chk("rst_pre_level", fifo_level, 1);
        chk("rst_pre_busy", bus_busy, 1);
        apply_reset();
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_level", fifo_level, 0);
        chk("rst_mid_busy", bus_busy, 0);
        rdy_val = 1; got_q.delete();
        for (int i = 0; i < 10; i++) send_bit(1'($urandom));
        set_sda(1'b0); set_scl(1'b1); set_sda(1'b1);
        wait_cyc(10);
        chk("rst_post_none", got_q.size(), 0);
        chk("rst_post_level", fifo_level, 0);
        chk("rst_post_busy", bus_busy, 0);

        rdy_rand = 1;
        for (int t = 0; t < 16; t++) begin
            a = $urandom_range(0, 1) ? {7'h50, 1'($urandom)} : 8'($urandom);
            bus_start(); send_byte(a, 1'($urandom));
            repeat ($urandom_range(0, 3)) send_byte(8'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 8)) send_bit(1'($urandom));
                a = $urandom_range(0, 1) ? {7'h50, 1'($urandom)} : 8'($urandom);
                bus_start(); send_byte(a, 1'($urandom));
            end
            bus_stop();
        end
        drain();
        chk("rand_ovf", ovf, m_ovf);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/i2c_sniff_fifo.md
Name: i2c_sniff_fifo

Overview:
- Parametrised next-generation passive I2C bus listener.
- Debounces SCL/SDA, detects START, repeated START and STOP, and decodes each 9-bit frame as data plus ACK/NACK.
- Optionally filters frames by a 7-bit target address.
- Queues tagged entries in an internal FIFO with a valid/ready output. It replaces the single-byte ready/sop/eot listener ahead of the buffer controller, so bursts survive consumer stalls.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on scl_in/sda_in; legal range 2..4.
- FILT_LEN, 3, consecutive identical synchronised samples required before a filtered line changes; legal range 1..15.
- DEPTH, 16, FIFO entries; power of 2, legal range 2..256.
- ADDR_MATCH_EN, 0, 1 = forward only transactions whose address byte [7:1] equals MATCH_ADDR.
- MATCH_ADDR, 7'h00, target address used when ADDR_MATCH_EN=1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- scl_in  input  1  raw bus SCL, asynchronous.
- sda_in  input  1  raw bus SDA, asynchronous.
- out_ready  input  1  consumer accepts the head entry.
- ovf_clr  input  1  clears the sticky overflow flag.
- out_valid  output  1  head entry valid.
- out_data  output  11  {kind[1:0], byte[7:0], nack}.
- fifo_level  output  $clog2(DEPTH)+1  current occupancy.
- ovf  output  1  sticky: a push was dropped because the FIFO was full.
- bus_busy  output  1  high from START until STOP.

Behaviour:
- Reset: synchronous on rst, one cycle.
  - Clears FIFO: out_valid=0, fifo_level=0.
  - ovf=0, bus_busy=0, out_data=0, decoder state=IDLE, bit counter=0.
  - Filtered lines preset to 1 (bus idle).
  - A reset mid-transaction abandons the transaction. No entries are produced until a new START is seen.
- Filtering:
  - Raw lines pass SYNC_STAGES flops.
  - A filtered line takes the new value after FILT_LEN consecutive equal samples that differ from its current value.
  - Edge detection runs on the filtered lines only.
- Bus events, all on filtered lines:
  - START = SDA 1->0 while SCL=1.
  - STOP = SDA 0->1 while SCL=1.
  - Bit sample = SCL 0->1; SDA is shifted in MSB first.
  - If START and STOP are both eligible in one cycle, which is impossible on the same SDA edge, none is missed.
- Entry kinds:
  - 2'b01 = first byte after START or repeated START (address).
  - 2'b00 = data byte.
  - 2'b10 = STOP marker, with byte=0 and nack=0.
  - 2'b11 = repeated-START-truncated marker, with byte=partial bits and nack=1.
- Decoder FSM:
  - IDLE: on START -> ADDR, set bus_busy=1, count=0. SCL edges are ignored in IDLE.
  - ADDR: 9 sampled bits; the 9th bit is nack (1 = NACK). After the 9th bit, push kind 01.
    - If ADDR_MATCH_EN=1 and byte[7:1] != MATCH_ADDR, go to SKIP and push nothing.
    - Otherwise go to DATA.
  - DATA: each 9-bit frame pushes kind 00; the counter wraps to 0.
  - SKIP: all bits discarded; STOP -> IDLE with no marker; START -> ADDR.
  - STOP in ADDR or DATA:
    - A partial frame (count 1..8) is discarded.
    - Push kind 10, go to IDLE, bus_busy=0.
  - START in ADDR or DATA:
    - If count != 0, push kind 11 first.
    - Go to ADDR with count=0. bus_busy stays 1.
  - Two pushes never occur in one cycle: a START cannot coincide with a 9th-bit SCL edge.
- Latency:
  - Push occurs in the cycle after the filtered SCL rising edge of bit 9.
  - out_valid rises the cycle after the push when the FIFO was empty.
  - Raw edge to out_valid = SYNC_STAGES + FILT_LEN + 2 cycles.
- FIFO:
  - Show-ahead: out_data holds the head entry whenever out_valid=1.
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop: level unchanged; legal when full because the pop frees a slot first.
  - Push when full without a pop: entry dropped, ovf set to 1; existing contents are preserved.
  - Pointers wrap modulo DEPTH.
  - fifo_level is a registered value, updated one cycle after the push or pop.
- Overflow flag: ovf_clr clears ovf. If ovf_clr and a new overflow coincide, ovf stays 1.

Test Plan:
- START, address 0xA0 ACK, data 0x3C ACK, data 0xFF NACK, STOP, out_ready=1 -> entries in order 01/A0/0, 00/3C/0, 00/FF/1, 10/00/0. bus_busy is high from START until STOP.
- Glitch test with FILT_LEN=3: 2-cycle SDA low pulse while SCL=1 -> no START and no entries. 4-cycle SDA low pulse while SCL=1 -> START detected.
- Truncation test: START, 0xA0, 4 bits of a data byte, then repeated START and 0xA1, then STOP -> entries 01/A0, 11/partial/1, 01/A1, 10.
- Overflow test with DEPTH=4, out_ready=0: send 6 data bytes -> level=4, ovf=1, first 4 entries intact. Pulse ovf_clr -> ovf=0.
- Address filter with ADDR_MATCH_EN=1, MATCH_ADDR=7'h50: send address 0xA2 (addr 0x51) plus 2 bytes + STOP -> no entries. Then send address 0xA0 + 1 byte + STOP -> 3 entries.
- Reset test: assert rst mid-byte in DATA -> next cycle out_valid=0, level=0, bus_busy=0. Further SCL edges without a START produce nothing.
